// File: rtl/m65c02_add_seq.sv
// Multi-byte ADC/SBC sequencer that owns the M65C02 binary/BCD adder, streaming byte pairs LSB-first.
// Optional zero-result flag output o_zo is enabled by defining ADD_SEQ_ZFLAG_EN.
module m65c02_add_seq #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_vld,
  output logic             o_cmd_rdy,
  input  logic             i_cmd_op,
  input  logic             i_cmd_d,
  input  logic             i_cmd_ci,
  input  logic [CNT_W-1:0] i_cmd_len,
  input  logic             i_in_vld,
  output logic             o_in_rdy,
  input  logic [7:0]       i_in_q,
  input  logic [7:0]       i_in_r,
  output logic             o_res_vld,
  output logic [7:0]       o_res_d,
  output logic             o_res_last,
  output logic             o_done,
  output logic             o_co,
  output logic             o_vo,
`ifdef ADD_SEQ_ZFLAG_EN
  output logic             o_zo,
`endif
  output logic             o_busy,
  output logic             o_en_au,
  output logic             o_en_du,
  output logic             o_op,
  output logic [7:0]       o_q,
  output logic [7:0]       o_r,
  output logic             o_ci,
  input  logic [8:0]       i_add_out,
  input  logic             i_add_ov,
  input  logic             i_add_val
);

  typedef enum logic [2:0] {StIdle, StBin, StDecA, StDecB, StFin} state_e;

  state_e           r_state, w_state_nxt;
  logic             r_op;
  logic [CNT_W-1:0] r_len, r_cnt;
  logic             r_carry, r_v;
  logic [7:0]       r_q_hold, r_r_hold, r_res_d;
  logic             r_res_vld, r_res_last;
  logic             w_cmd_acc, w_byte_done, w_last;

  assign w_cmd_acc   = (r_state == StIdle) & i_cmd_vld;
  assign w_last      = (r_cnt == r_len);
  // BCD carry resolves only in the second adder cycle, so DECB always completes a byte.
  assign w_byte_done = ((r_state == StBin) & i_in_vld) | (r_state == StDecB);

  always_comb begin
    w_state_nxt = r_state;
    o_cmd_rdy   = 1'b0;
    o_in_rdy    = 1'b0;
    o_done      = 1'b0;
    o_en_au     = 1'b0;
    o_en_du     = 1'b0;
    o_q         = '0;
    o_r         = '0;
    o_ci        = 1'b0;
    case (r_state)
      StIdle: begin
        o_cmd_rdy = 1'b1;
        if (i_cmd_vld) w_state_nxt = i_cmd_d ? StDecA : StBin;
      end
      StBin: begin
        o_in_rdy = 1'b1;
        if (i_in_vld) begin
          o_en_au = 1'b1;
          o_q     = i_in_q;
          o_r     = i_in_r;
          o_ci    = r_carry;
          if (w_last) w_state_nxt = StFin;
        end
      end
      StDecA: begin
        o_in_rdy = 1'b1;
        if (i_in_vld) begin
          o_en_du     = 1'b1;
          o_q         = i_in_q;
          o_r         = i_in_r;
          o_ci        = r_carry;
          w_state_nxt = StDecB;
        end
      end
      StDecB: begin
        // Dropping En_DU here would clear the adder's decimal pipeline.
        o_en_du     = 1'b1;
        o_q         = r_q_hold;
        o_r         = r_r_hold;
        o_ci        = r_carry;
        w_state_nxt = w_last ? StFin : StDecA;
      end
      StFin: begin
        o_done      = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_op       <= 1'b0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_v        <= 1'b0;
      r_q_hold   <= '0;
      r_r_hold   <= '0;
      r_res_d    <= '0;
      r_res_vld  <= 1'b0;
      r_res_last <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_res_vld  <= w_byte_done;
      r_res_last <= w_byte_done & w_last;
      if (w_cmd_acc) begin
        r_op    <= i_cmd_op;
        r_len   <= i_cmd_len;
        r_carry <= i_cmd_ci;
        r_cnt   <= '0;
      end
      if ((r_state == StDecA) & i_in_vld) begin
        r_q_hold <= i_in_q;
        r_r_hold <= i_in_r;
      end
      if (w_byte_done) begin
        r_res_d <= i_add_out[7:0];
        r_carry <= i_add_out[8];
        r_v     <= i_add_ov;
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

`ifdef ADD_SEQ_ZFLAG_EN
  logic r_zero;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_zero <= 1'b0;
    end else if (w_cmd_acc) begin
      r_zero <= 1'b1;
    end else if (w_byte_done) begin
      r_zero <= r_zero & (i_add_out[7:0] == 8'h00);
    end
  end

  assign o_zo = r_zero;
`endif

  assign o_res_vld  = r_res_vld;
  assign o_res_d    = r_res_d;
  assign o_res_last = r_res_last;
  assign o_co       = r_carry;
  assign o_vo       = r_v;
  assign o_busy     = (r_state != StIdle);
  assign o_op       = r_op;

  a_dec_val: assert property (@(posedge i_clk) disable iff (i_rst)
    (r_state == StDecB) |-> i_add_val);
  a_en_excl: assert property (@(posedge i_clk) disable iff (i_rst) !(o_en_au && o_en_du));

endmodule

// File: tb/tb_m65c02_add_seq.sv
// Self-checking bench for m65c02_add_seq with a behavioural binary/BCD adder and result scoreboard.
module tb_m65c02_add_seq;
  localparam int unsigned CNT_W = 4;

  logic             clk, rst;
  logic             cmd_vld, cmd_rdy, cmd_op, cmd_d, cmd_ci;
  logic [CNT_W-1:0] cmd_len;
  logic             in_vld, in_rdy;
  logic [7:0]       in_q, in_r;
  logic             res_vld, res_last, done, co, vo, busy;
  logic [7:0]       res_d;
  logic             en_au, en_du, op, ci;
  logic [7:0]       q, r;
  logic [8:0]       add_out;
  logic             add_ov, add_val;
`ifdef ADD_SEQ_ZFLAG_EN
  logic             zo;
`endif

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int du_cnt = 0;
  logic [8:0] exp_q[$];

  m65c02_add_seq #(.CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_vld(cmd_vld), .o_cmd_rdy(cmd_rdy), .i_cmd_op(cmd_op), .i_cmd_d(cmd_d),
    .i_cmd_ci(cmd_ci), .i_cmd_len(cmd_len),
    .i_in_vld(in_vld), .o_in_rdy(in_rdy), .i_in_q(in_q), .i_in_r(in_r),
    .o_res_vld(res_vld), .o_res_d(res_d), .o_res_last(res_last), .o_done(done),
    .o_co(co), .o_vo(vo),
`ifdef ADD_SEQ_ZFLAG_EN
    .o_zo(zo),
`endif
    .o_busy(busy), .o_en_au(en_au), .o_en_du(en_du), .o_op(op),
    .o_q(q), .o_r(r), .o_ci(ci),
    .i_add_out(add_out), .i_add_ov(add_ov), .i_add_val(add_val)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [8:0] bcd_calc(input logic sub, input logic [7:0] a,
                                          input logic [7:0] b, input logic c);
    int lo, hi, k;
    k = 0;
    if (!sub) begin
      lo = int'(a[3:0]) + int'(b[3:0]) + (c ? 1 : 0);
      if (lo > 9) begin lo = lo - 10; k = 1; end
      hi = int'(a[7:4]) + int'(b[7:4]) + k;
      k = 0;
      if (hi > 9) begin hi = hi - 10; k = 1; end
    end else begin
      lo = int'(a[3:0]) - int'(b[3:0]) - (c ? 0 : 1);
      if (lo < 0) begin lo = lo + 10; k = 1; end
      hi = int'(a[7:4]) - int'(b[7:4]) - k;
      k = 1;
      if (hi < 0) begin hi = hi + 10; k = 0; end
    end
    return {k[0], hi[3:0], lo[3:0]};
  endfunction

  // Adder stand-in: decimal result is only valid on the second consecutive En_DU-only cycle.
  logic       du_q;
  logic [7:0] rr;
  logic [8:0] s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) du_q <= 1'b0;
    else     du_q <= en_du & ~en_au;
  end

  always_comb begin
    add_out = '0;
    add_ov  = 1'b0;
    rr      = '0;
    s       = '0;
    if (en_au && !en_du) begin
      rr      = op ? ~r : r;
      s       = {1'b0, q} + {1'b0, rr} + {8'b0, ci};
      add_out = s;
      add_ov  = (q[7] == rr[7]) && (s[7] != q[7]);
    end else if (en_du && !en_au) begin
      add_out = bcd_calc(op, q, r, ci);
    end
  end

  assign add_val = (en_au & ~en_du) | (en_du & ~en_au & du_q);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (res_vld) begin
        if (exp_q.size() == 0) begin
          chk("res_unexpected", 32'(res_d), 32'h1ff);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("res_d", 32'(res_d), 32'(e[7:0]));
          chk("res_last", 32'(res_last), 32'(e[8]));
        end
      end
      if (en_au || en_du) chk("en_excl", 32'(en_au & en_du), 0);
      if (done) done_cnt++;
      if (en_du) du_cnt++;
    end
  end

  task automatic do_cmd(input logic o, input logic d, input logic c, input logic [CNT_W-1:0] l);
    int n = 0;
    cmd_vld = 1'b1; cmd_op = o; cmd_d = d; cmd_ci = c; cmd_len = l;
    while (!cmd_rdy && n < 20) begin @(negedge clk); n++; end
    chk("cmd_rdy_wait", 32'(cmd_rdy), 1);
    @(negedge clk);
    cmd_vld = 1'b0;
    chk("busy_after_acc", 32'(busy), 1);
    chk("cmd_rdy_busy", 32'(cmd_rdy), 0);
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic push,
                           input logic [7:0] ed, input logic el);
    int n = 0;
    in_vld = 1'b1; in_q = a; in_r = b;
    while (!in_rdy && n < 20) begin @(negedge clk); n++; end
    chk("in_rdy_wait", 32'(in_rdy), 1);
    if (push) exp_q.push_back({el, ed});
    @(negedge clk);
    in_vld = 1'b0; in_q = '0; in_r = '0;
  endtask

  task automatic finish_cmd(input string tag, input logic eco, input logic evo, input int d0);
    int n = 0;
    while (!done && n < 10) begin @(negedge clk); n++; end
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_co"}, 32'(co), 32'(eco));
    chk({tag, "_vo"}, 32'(vo), 32'(evo));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 0);
    chk({tag, "_busy_off"}, 32'(busy), 0);
    chk({tag, "_co_hold"}, 32'(co), 32'(eco));
    chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int d0, u0;
    logic [7:0] a, b, ed;
    logic       c, v;
    int         sum;

    rst = 1'b1; cmd_vld = 1'b0; cmd_op = 1'b0; cmd_d = 1'b0; cmd_ci = 1'b0; cmd_len = '0;
    in_vld = 1'b0; in_q = '0; in_r = '0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_rdy", 32'(cmd_rdy), 1);
    chk("rst_in_rdy", 32'(in_rdy), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_res_vld", 32'(res_vld), 0);
    chk("rst_res_d", 32'(res_d), 0);
    chk("rst_en", 32'({en_au, en_du, op, ci}), 0);
    chk("rst_qr", 32'({q, r}), 0);
    chk("rst_flags", 32'({co, vo}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Binary ADC, two bytes back-to-back with carry between them.
    d0 = done_cnt;
    do_cmd(1'b0, 1'b0, 1'b0, 4'd1);
    send_pair(8'hff, 8'h01, 1'b1, 8'h00, 1'b0);
    chk("bin_lat0", 32'(res_vld), 1);
    send_pair(8'h12, 8'h00, 1'b1, 8'h13, 1'b1);
    chk("bin_lat1", 32'(res_vld), 1);
    chk("bin_last", 32'(res_last), 1);
    finish_cmd("bin2", 1'b0, 1'b0, d0);

    d0 = done_cnt;
    do_cmd(1'b0, 1'b0, 1'b0, 4'd0);
    send_pair(8'h7f, 8'h01, 1'b1, 8'h80, 1'b1);
    finish_cmd("bin_ovf", 1'b0, 1'b1, d0);
`ifdef ADD_SEQ_ZFLAG_EN
    chk("bin_ovf_zo", 32'(zo), 0);
`endif

    // Decimal ADC: two adder cycles per byte.
    d0 = done_cnt; u0 = du_cnt;
    do_cmd(1'b0, 1'b1, 1'b0, 4'd1);
    send_pair(8'h99, 8'h01, 1'b1, 8'h00, 1'b0);
    chk("decb_in_rdy", 32'(in_rdy), 0);
    chk("decb_en_du", 32'(en_du), 1);
    chk("decb_res_vld", 32'(res_vld), 0);
    @(negedge clk);
    chk("dec_lat2", 32'(res_vld), 1);
    send_pair(8'h01, 8'h00, 1'b1, 8'h02, 1'b1);
    finish_cmd("dec_adc", 1'b0, vo, d0);
    chk("dec_du_cycles", 32'(du_cnt - u0), 4);
`ifdef ADD_SEQ_ZFLAG_EN
    chk("dec_adc_zo", 32'(zo), 0);
`endif

    d0 = done_cnt;
    do_cmd(1'b1, 1'b1, 1'b1, 4'd0);
    send_pair(8'h00, 8'h01, 1'b1, 8'h99, 1'b1);
    finish_cmd("dec_sbc_b", 1'b0, vo, d0);
    d0 = done_cnt;
    do_cmd(1'b1, 1'b1, 1'b1, 4'd0);
    send_pair(8'h50, 8'h25, 1'b1, 8'h25, 1'b1);
    finish_cmd("dec_sbc_nb", 1'b1, vo, d0);

    // Decimal stream with In_Vld gaps: adder must be fully disabled while stalled.
    d0 = done_cnt; u0 = du_cnt;
    do_cmd(1'b0, 1'b1, 1'b0, 4'd1);
    send_pair(8'h99, 8'h01, 1'b1, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("gap_en", 32'({en_au, en_du}), 0);
    end
    send_pair(8'h01, 8'h00, 1'b1, 8'h02, 1'b1);
    finish_cmd("dec_gap", 1'b0, vo, d0);
    chk("gap_du_cycles", 32'(du_cnt - u0), 4);

    d0 = done_cnt;
    do_cmd(1'b1, 1'b0, 1'b1, 4'd0);
    send_pair(8'h00, 8'h01, 1'b1, 8'hff, 1'b1);
    finish_cmd("bin_sbc", 1'b0, 1'b0, d0);

    // Full-length binary command.
    d0 = done_cnt;
    c = 1'b1; v = 1'b0;
    do_cmd(1'b0, 1'b0, c, 4'd15);
    for (int i = 0; i < 16; i++) begin
      a   = 8'(i * 37 + 3);
      b   = 8'(200 - i * 9);
      sum = int'(a) + int'(b) + (c ? 1 : 0);
      ed  = 8'(sum);
      c   = (sum > 255);
      v   = (a[7] == b[7]) && (ed[7] != a[7]);
      send_pair(a, b, 1'b1, ed, (i == 15));
    end
    finish_cmd("bin_full", c, v, d0);

`ifdef ADD_SEQ_ZFLAG_EN
    d0 = done_cnt;
    do_cmd(1'b0, 1'b0, 1'b0, 4'd1);
    send_pair(8'h00, 8'h00, 1'b1, 8'h00, 1'b0);
    send_pair(8'h80, 8'h80, 1'b1, 8'h00, 1'b1);
    finish_cmd("zero", 1'b1, 1'b1, d0);
    chk("zero_zo", 32'(zo), 1);
`endif

    // Reset while in DECB of a 4-byte decimal command.
    d0 = done_cnt;
    do_cmd(1'b0, 1'b1, 1'b0, 4'd3);
    send_pair(8'h12, 8'h34, 1'b0, 8'h00, 1'b0);
    chk("abort_in_decb", 32'(en_du), 1);
    rst = 1'b1;
    #1;
    chk("abort_cmd_rdy", 32'(cmd_rdy), 1);
    chk("abort_busy", 32'({busy, in_rdy, done}), 0);
    chk("abort_en", 32'({en_au, en_du, op, ci}), 0);
    chk("abort_qr", 32'({q, r}), 0);
    chk("abort_res", 32'({res_vld, res_last, res_d}), 0);
    chk("abort_flags", 32'({co, vo}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 0);

    d0 = done_cnt;
    do_cmd(1'b0, 1'b0, 1'b0, 4'd0);
    send_pair(8'h01, 8'h01, 1'b1, 8'h02, 1'b1);
    finish_cmd("post_rst", 1'b0, 1'b0, d0);

    repeat (2) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
